// File: rtl/alu_arbiter_if.sv
// Bundle between two requesters, the shared 4-bit ALU and the response consumer.
// master = environment side (requesters, ALU, consumer); slave = arbiter side.
interface alu_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [1:0] req0_op;
    logic [3:0] req0_a;
    logic [3:0] req0_b;

    logic       req1_valid;
    logic       req1_ready;
    logic [1:0] req1_op;
    logic [3:0] req1_a;
    logic [3:0] req1_b;

    logic [1:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_result;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_data;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU between two requesters; one command
// in flight at a time, result held in RESP until the consumer takes it.
module alu_arbiter #(
    parameter int ALU_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(ALU_LATENCY - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_id;
    logic [3:0] r_rsp_data;
    logic [1:0] r_cnt;
    logic       r_last;

    logic       w_any_valid;
    logic       w_grant_id;
    logic       w_accept;
    logic       w_exec_done;

    // Tie goes to the requester that was not granted most recently.
    always_comb begin
        w_any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = ~r_last;
        end else begin
            w_grant_id = bus.req1_valid;
        end
    end

    assign w_accept    = (r_state == IDLE) && w_any_valid && !rst;
    assign w_exec_done = (r_state == EXEC) && (r_cnt == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_valid) w_next = EXEC;
            EXEC:    if (r_cnt == 2'd0) w_next = RESP;
            RESP:    if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= 2'd0;
            r_a        <= 4'd0;
            r_b        <= 4'd0;
            r_id       <= 1'b0;
            r_rsp_data <= 4'd0;
            r_cnt      <= 2'd0;
            r_last     <= 1'b1;
        end else begin
            if (w_accept) begin
                r_op   <= w_grant_id ? bus.req1_op : bus.req0_op;
                r_a    <= w_grant_id ? bus.req1_a  : bus.req0_a;
                r_b    <= w_grant_id ? bus.req1_b  : bus.req0_b;
                r_id   <= w_grant_id;
                r_last <= w_grant_id;
                r_cnt  <= CNT_INIT;
            end else if ((r_state == EXEC) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_exec_done) begin
                r_rsp_data <= bus.alu_result;
            end
        end
    end

    always_comb begin
        bus.req0_ready = w_accept && !w_grant_id;
        bus.req1_ready = w_accept && w_grant_id;
        bus.rsp_valid  = (r_state == RESP);
    end

    assign bus.alu_op   = r_op;
    assign bus.alu_a    = r_a;
    assign bus.alu_b    = r_b;
    assign bus.rsp_id   = r_id;
    assign bus.rsp_data = r_rsp_data;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, scoreboard monitor and hand-written
// sequences for ties, backpressure, reset abort and a latency-3 instance.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if b1();
    alu_arbiter_if b3();

    alu_arbiter #(.ALU_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    alu_arbiter #(.ALU_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign b1.alu_result = alu_f(b1.alu_op, b1.alu_a, b1.alu_b);
    assign b3.alu_result = alu_f(b3.alu_op, b3.alu_a, b3.alu_b);

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected responses pushed on accept, popped on handshake.
    typedef struct packed {
        logic       id;
        logic [3:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   cyc = 0;
    int   acc_cyc = 0;
    logic pend = 1'b0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            pend   <= 1'b0;
            prev_v <= 1'b0;
        end else begin
            if (b1.req0_valid && b1.req1_valid)
                check("one_grant", 32'(b1.req0_ready & b1.req1_ready), 32'd0);
            if (b1.req0_valid && b1.req0_ready) begin
                sb.push_back('{id: 1'b0, data: alu_f(b1.req0_op, b1.req0_a, b1.req0_b)});
                acc_cyc <= cyc;
                pend    <= 1'b1;
            end
            if (b1.req1_valid && b1.req1_ready) begin
                sb.push_back('{id: 1'b1, data: alu_f(b1.req1_op, b1.req1_a, b1.req1_b)});
                acc_cyc <= cyc;
                pend    <= 1'b1;
            end
            if (b1.rsp_valid && !prev_v) begin
                check("rsp_has_cmd", 32'(pend), 32'd1);
                if (pend) check("sb_latency", 32'(cyc - acc_cyc), 32'd2);
                pend <= 1'b0;
            end
            if (b1.rsp_valid && b1.rsp_ready) begin
                check("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    check("sb_id", 32'(b1.rsp_id), 32'(sb[0].id));
                    check("sb_data", 32'(b1.rsp_data), 32'(sb[0].data));
                    void'(sb.pop_front());
                end
            end
            prev_v <= b1.rsp_valid;
        end
    end

    typedef struct {
        logic       sel;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec_t;

    vec_t vt[8];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic sel, input logic v, input logic [1:0] op,
                           input logic [3:0] a, input logic [3:0] b);
        if (!sel) begin
            b1.req0_valid = v; b1.req0_op = op; b1.req0_a = a; b1.req0_b = b;
        end else begin
            b1.req1_valid = v; b1.req1_op = op; b1.req1_a = a; b1.req1_b = b;
        end
    endtask

    task automatic wait_rsp_done();
        int n = 0;
        while (!(b1.rsp_valid && b1.rsp_ready) && n < 30) begin
            tick();
            n++;
        end
        check("rsp_done_in_time", 32'(n < 30), 32'd1);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_valid"}, 32'(b1.rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(b1.rsp_id),    32'd0);
        check({tag, "_rsp_data"},  32'(b1.rsp_data),  32'd0);
        check({tag, "_alu_op"},    32'(b1.alu_op),    32'd0);
        check({tag, "_alu_a"},     32'(b1.alu_a),     32'd0);
        check({tag, "_alu_b"},     32'(b1.alu_b),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   g[$];
        int   gc[$];
        int   n;

        vt[0] = '{1'b0, 2'd2, 4'hA, 4'h6, 4'hC};
        vt[1] = '{1'b1, 2'd0, 4'hF, 4'h3, 4'h3};
        vt[2] = '{1'b0, 2'd1, 4'h8, 4'h1, 4'h9};
        vt[3] = '{1'b1, 2'd3, 4'h5, 4'h0, 4'hA};
        vt[4] = '{1'b0, 2'd0, 4'hC, 4'hA, 4'h8};
        vt[5] = '{1'b1, 2'd1, 4'h0, 4'h0, 4'h0};
        vt[6] = '{1'b0, 2'd2, 4'hF, 4'hF, 4'h0};
        vt[7] = '{1'b1, 2'd3, 4'h0, 4'h7, 4'hF};

        rst = 1'b1;
        set_req(1'b0, 1'b1, 2'd0, 4'hF, 4'h3);
        set_req(1'b1, 1'b1, 2'd1, 4'h8, 4'h1);
        b1.rsp_ready = 1'b1;
        b3.req0_valid = 1'b0; b3.req0_op = 2'd0; b3.req0_a = 4'h0; b3.req0_b = 4'h0;
        b3.req1_valid = 1'b0; b3.req1_op = 2'd0; b3.req1_a = 4'h0; b3.req1_b = 4'h0;
        b3.rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_ready0", 32'(b1.req0_ready), 32'd0);
        check("rst_ready1", 32'(b1.req1_ready), 32'd0);
        check_all_zero("rst");

        // Tie right after reset: grants alternate starting with requester 0.
        rst = 1'b0;
        #1;
        n = 0;
        while (g.size() < 4 && n < 40) begin
            if (b1.req0_ready) g.push_back(0);
            else if (b1.req1_ready) g.push_back(1);
            tick();
            #1;
            n++;
        end
        check("tie_count", 32'(g.size()), 32'd4);
        for (int i = 0; i < g.size(); i++) check("tie_grant", 32'(g[i]), 32'(i % 2));
        set_req(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
        set_req(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
        wait_rsp_done();

        for (int i = 0; i < 8; i++) begin
            set_req(vt[i].sel, 1'b1, vt[i].op, vt[i].a, vt[i].b);
            #1;
            check("vec_ready", 32'(vt[i].sel ? b1.req1_ready : b1.req0_ready), 32'd1);
            check("vec_other_ready", 32'(vt[i].sel ? b1.req0_ready : b1.req1_ready), 32'd0);
            tick();
            set_req(vt[i].sel, 1'b0, 2'd0, 4'h0, 4'h0);
            lat = 1;
            while (!b1.rsp_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("vec_latency", 32'(lat), 32'd2);
            check("vec_data", 32'(b1.rsp_data), 32'(vt[i].exp));
            check("vec_id", 32'(b1.rsp_id), 32'(vt[i].sel));
            tick();
            check("vec_idle", 32'(b1.rsp_valid), 32'd0);
        end

        // Backpressure: five stalled RESP cycles, handshake on the sixth.
        b1.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 2'd1, 4'h3, 4'h4);
        #1;
        check("bp_accept", 32'(b1.req0_ready), 32'd1);
        tick();
        set_req(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
        tick();
        set_req(1'b1, 1'b1, 2'd0, 4'hF, 4'h3);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", 32'(b1.rsp_valid), 32'd1);
            check("bp_data", 32'(b1.rsp_data), 32'h7);
            check("bp_id", 32'(b1.rsp_id), 32'd0);
            check("bp_alu_op", 32'(b1.alu_op), 32'd1);
            check("bp_alu_a", 32'(b1.alu_a), 32'h3);
            check("bp_alu_b", 32'(b1.alu_b), 32'h4);
            check("bp_ready1", 32'(b1.req1_ready), 32'd0);
            tick();
        end
        b1.rsp_ready = 1'b1;
        #1;
        check("hs_valid", 32'(b1.rsp_valid), 32'd1);
        check("hs_no_accept", 32'(b1.req1_ready), 32'd0);
        tick();
        #1;
        check("post_hs_idle", 32'(b1.rsp_valid), 32'd0);
        check("post_hs_accept", 32'(b1.req1_ready), 32'd1);
        tick();
        set_req(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
        wait_rsp_done();

        // Reset one cycle after accept aborts the command and re-arms the pointer.
        set_req(1'b0, 1'b1, 2'd2, 4'h1, 4'h2);
        #1;
        check("mr_accept", 32'(b1.req0_ready), 32'd1);
        tick();
        set_req(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mr");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mr_no_rsp", 32'(b1.rsp_valid), 32'd0);
        end
        set_req(1'b0, 1'b1, 2'd3, 4'h6, 4'h0);
        set_req(1'b1, 1'b1, 2'd0, 4'h7, 4'h1);
        #1;
        check("mr_tie_ready0", 32'(b1.req0_ready), 32'd1);
        check("mr_tie_ready1", 32'(b1.req1_ready), 32'd0);
        tick();
        set_req(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
        set_req(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
        wait_rsp_done();

        // Lone requester 1 held valid: granted every ALU_LATENCY+2 cycles.
        set_req(1'b1, 1'b1, 2'd1, 4'h2, 4'h4);
        for (int i = 0; i < 12; i++) begin
            #1;
            if (b1.req1_ready) gc.push_back(i);
            check("ss_ready0", 32'(b1.req0_ready), 32'd0);
            tick();
        end
        set_req(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
        check("ss_count", 32'(gc.size()), 32'd4);
        for (int i = 1; i < gc.size(); i++) check("ss_spacing", 32'(gc[i] - gc[i-1]), 32'd3);
        tick();
        tick();

        // Latency-3 instance: NOT of 4'h5.
        b3.req0_op = 2'd3; b3.req0_a = 4'h5; b3.req0_b = 4'h0; b3.req0_valid = 1'b1;
        #1;
        check("l3_accept", 32'(b3.req0_ready), 32'd1);
        tick();
        b3.req0_valid = 1'b0;
        lat = 1;
        while (!b3.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("l3_latency", 32'(lat), 32'd4);
        check("l3_data", 32'(b3.rsp_data), 32'hA);
        check("l3_id", 32'(b3.rsp_id), 32'd0);
        tick();
        check("l3_done", 32'(b3.rsp_valid), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LATENCY, default 1, cycles from operand issue to valid alu_result; legal range 1..3.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a command
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_op  in  2  requester 0 opcode
- req0_a  in  4  requester 0 operand a
- req0_b  in  4  requester 0 operand b
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- alu_op  out  2  opcode to shared 4-bit ALU (drives MUX_4bit selects: op[0]=op_1, op[1]=op_2)
- alu_a  out  4  operand a to shared ALU
- alu_b  out  4  operand b to shared ALU
- alu_result  in  4  selected result from shared ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index owning the response
- rsp_data  out  4  captured ALU result

Function
REQ-003 Opcode encoding SHALL be 00 AND, 01 OR, 10 XOR, 11 NOT(a); b ignored for NOT; block passes op unmodified.
REQ-004 FSM SHALL have states IDLE, EXEC, RESP only.
REQ-005 IDLE: if any reqN_valid, grant exactly one, assert its reqN_ready combinationally that cycle, capture op/a/b/id into registers, go to EXEC.
REQ-006 Arbitration SHALL be round-robin: when both valid, grant the requester not granted most recently; single valid requester always granted.
REQ-007 reqN_ready SHALL be 0 in EXEC and RESP, and never high for both requesters in one cycle.
REQ-008 alu_op/alu_a/alu_b SHALL be driven from captured registers and remain stable from the accept cycle+1 through RESP exit.
REQ-009 EXEC SHALL last exactly ALU_LATENCY cycles (2-bit down counter); alu_result sampled into rsp_data on the last EXEC edge; then go to RESP.
REQ-010 RESP: rsp_valid=1, rsp_id and rsp_data stable until rsp_valid&&rsp_ready, then go to IDLE.
REQ-011 Accept-to-rsp_valid latency SHALL be ALU_LATENCY+1 cycles; no new accept in the cycle of response handshake (next accept earliest one cycle after).
REQ-012 Requester command fields SHALL be ignored in cycles where its ready is 0; a valid dropped before grant is not recorded.
REQ-013 rsp_ready held low SHALL stall indefinitely in RESP with no data loss and no new grants.
REQ-014 Round-robin pointer SHALL update only on grant, not on response.

Reset
REQ-015 rst high SHALL, at next edge, force IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, alu_op=0, alu_a=0, alu_b=0, counter=0, and set last-grant pointer to 1 so requester 0 wins the first tie.
REQ-016 rst during EXEC or RESP SHALL abort the transaction; no response for it is ever produced.
REQ-017 While rst high, req0_ready and req1_ready SHALL be 0.

Verification
REQ-018 Single op: ALU_LATENCY=1, req0 op=10 a=4'hA b=4'h6 -> req0_ready on cycle 0, rsp_valid on cycle 2, rsp_id=0, rsp_data=4'hC.
REQ-019 Tie after reset: both valid continuously, req0 AND 4'hF/4'h3, req1 OR 4'h8/4'h1 -> grants 0,1,0,1; responses 4'h3 id0, 4'h9 id1 alternating.
REQ-020 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id, alu_* unchanged; req ready stays 0; handshake on 6th cycle, IDLE next.
REQ-021 Latency sweep: ALU_LATENCY=3, NOT a=4'h5 -> rsp_valid exactly 4 cycles after accept, rsp_data=4'hA.
REQ-022 Reset mid-EXEC: assert rst one cycle after accept -> all outputs zero next edge, no rsp_valid ever for that command; next tie grants req0.
REQ-023 Single requester: only req1 valid back-to-back -> req1 granted every transaction, spacing ALU_LATENCY+2 cycles with rsp_ready=1.
